// File: rtl/ota_sar_ctrl_if.sv
// ota_sar_ctrl_if
//   Groups the conversion handshake, the comparator decision and the
//   front-end/DAC drive of the SAR controller.
//   master : tile side. Drives start and cmp_in, observes everything else.
//   slave  : controller side (ota_sar_ctrl).
//   Signals:
//     start    conversion request, only looked at while idle
//     cmp_in   raw comparator output (asynchronous), 1 = input above DAC level
//     sample   track/hold strobe
//     cmp_en   comparator enable
//     dac_code trial code for the reference DAC
//     busy     conversion in progress
//     done     one-cycle completion pulse
//     result   last completed conversion
interface ota_sar_ctrl_if #(
  parameter int N = 6
);
  logic         start;
  logic         cmp_in;
  logic         sample;
  logic         cmp_en;
  logic [N-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, cmp_in,
    input  sample, cmp_en, dac_code, busy, done, result
  );

  modport slave (
    input  start, cmp_in,
    output sample, cmp_en, dac_code, busy, done, result
  );
endinterface

// File: rtl/ota_sar_ctrl.sv
// ota_sar_ctrl
//   Successive-approximation controller for the inverter-based OTA
//   comparator. Samples the input, walks a binary-weighted DAC trial code
//   from MSB to LSB, resynchronises the comparator decision and hands back
//   an N-bit result with a start/done handshake.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  ota_sar_ctrl_if.slave (start, cmp_in in; sample, cmp_en,
//          dac_code, busy, done, result out)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start, all strobes low
//   SAMPLE  | track/hold strobe high for SAMPLE_CYC cycles
//   SETTLE  | trial code on the DAC, comparator settling for SETTLE cycles
//   DECIDE  | commit or drop the current bit from the synchronised decision
//   DONE    | result valid, one-cycle done pulse
module ota_sar_ctrl #(
  parameter int N           = 6,
  parameter int SAMPLE_CYC  = 4,
  parameter int SETTLE      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ota_sar_ctrl_if.slave bus
);

  localparam int CNT_MAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counter reload values: the state is left on the cycle the count hits 0.
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE - 1);
  localparam logic [IW-1:0] BIT_MSB    = IW'(N - 1);
  localparam logic [N-1:0]  ONE_LSB    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ONE_MSB    = {1'b1, {(N-1){1'b0}}};

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          bit_q, bit_d;
  logic [N-1:0]           code_q, code_d;
  logic [N-1:0]           dac_q, dac_d;
  logic [N-1:0]           result_q, result_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic                   cmp_sync;
  logic [N-1:0]           cur_mask;
  logic [N-1:0]           next_mask;
  logic [N-1:0]           code_commit;

  // The synchroniser runs in every state so the decision seen in DECIDE is
  // always the value captured SYNC_STAGES edges earlier.
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], bus.cmp_in};
  assign cmp_sync  = sync_q[SYNC_STAGES-1];

  assign cur_mask    = ONE_LSB << bit_q;
  assign next_mask   = ONE_LSB << (bit_q - IW'(1));
  assign code_commit = cmp_sync ? (code_q | cur_mask) : code_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    dac_d    = dac_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SAMPLE;
          cnt_d   = CNT_SAMPLE;
          code_d  = '0;
          dac_d   = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_SETTLE;
          bit_d   = BIT_MSB;
          dac_d   = ONE_MSB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DECIDE: begin
        code_d = code_commit;
        if (bit_q == '0) begin
          // Result and DAC are loaded together so result never shows a
          // partially resolved code.
          state_d  = S_DONE;
          result_d = code_commit;
          dac_d    = code_commit;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = CNT_SETTLE;
          bit_d   = bit_q - IW'(1);
          dac_d   = code_commit | next_mask;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      dac_q    <= '0;
      result_q <= '0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sync_q   <= sync_d;
    end
  end

  assign bus.sample   = (state_q == S_SAMPLE);
  assign bus.cmp_en   = (state_q == S_SETTLE) || (state_q == S_DECIDE);
  assign bus.busy     = (state_q == S_SAMPLE) || (state_q == S_SETTLE) ||
                        (state_q == S_DECIDE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.dac_code = dac_q;
  assign bus.result   = result_q;

endmodule

// File: tb/tb_ota_sar_ctrl.sv
// tb_ota_sar_ctrl
//   Directed bench for ota_sar_ctrl with default parameters (N=6,
//   SAMPLE_CYC=4, SETTLE=3, SYNC_STAGES=2). A behavioural comparator drives
//   cmp_in from the DAC code it sees; expected codes are hand-computed.
module tb_ota_sar_ctrl;

  localparam int M_IDEAL = 0;
  localparam int M_ONE   = 1;
  localparam int M_ZERO  = 2;
  localparam int M_WIN   = 3;
  localparam int M_LATE  = 4;
  localparam int M_RAND  = 5;

  logic       clk;
  logic       rst;
  int         n_checks = 0;
  int         n_errors = 0;
  int         mode     = M_ZERO;
  int         level    = 45;
  int         age      = 0;
  logic [5:0] prev_dac = '0;

  ota_sar_ctrl_if #(.N(6)) bus ();

  ota_sar_ctrl #(
    .N(6), .SAMPLE_CYC(4), .SETTLE(3), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model. age counts edges since the DAC code last changed, so
  // the window modes can place the correct decision relative to the DECIDE
  // edge d = (code-change edge) + 4.
  always @(posedge clk) begin
    logic good;
    #1;
    if (bus.dac_code !== prev_dac) age = 0;
    else age = age + 1;
    prev_dac = bus.dac_code;
    good = (level >= int'(bus.dac_code));
    case (mode)
      M_ONE:   bus.cmp_in = 1'b1;
      M_ZERO:  bus.cmp_in = 1'b0;
      M_WIN:   bus.cmp_in = (age >= 1) ? good : !good;
      M_LATE:  bus.cmp_in = (bus.dac_code == 6'd40 && age < 3) ? !good : good;
      M_RAND:  bus.cmp_in = 1'($urandom_range(0, 1));
      default: bus.cmp_in = good;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sample"}, 32'(bus.sample), 0);
    chk({tag, "_cmp_en"}, 32'(bus.cmp_en), 0);
    chk({tag, "_busy"},   32'(bus.busy),   0);
    chk({tag, "_done"},   32'(bus.done),   0);
    chk({tag, "_dac"},    32'(bus.dac_code), 0);
    chk({tag, "_result"}, 32'(bus.result), 0);
  endtask

  // One full conversion. Offset t means #1 after edge k+t, k being the
  // edge that samples start. seq holds the six trial codes, MSB trial first.
  task automatic conv(input string tag, input logic [35:0] seq, input logic [5:0] res,
                      input bit hold, input int pulse_at);
    int dones = 0;
    bus.start = 1'b1;
    tick(1);
    for (int t = 0; t <= 28; t++) begin
      if (t > 0) tick(1);
      bus.start = hold || (t == pulse_at);
      if (bus.done) dones++;
      if (t == 0) begin
        chk({tag, "_busy_start"},   32'(bus.busy),   1);
        chk({tag, "_sample_start"}, 32'(bus.sample), 1);
      end
      if (t == 3) chk({tag, "_sample_last"}, 32'(bus.sample), 1);
      if (t == 4) begin
        chk({tag, "_sample_off"}, 32'(bus.sample), 0);
        chk({tag, "_cmp_en"},     32'(bus.cmp_en), 1);
      end
      for (int j = 0; j < 6; j++) begin
        if (t == 4 + 4 * j || t == 7 + 4 * j)
          chk($sformatf("%s_trial%0d_t%0d", tag, j, t), 32'(bus.dac_code),
              32'(seq[35 - 6 * j -: 6]));
      end
    end
    chk({tag, "_done"},    32'(bus.done),     1);
    chk({tag, "_busy_dn"}, 32'(bus.busy),     0);
    chk({tag, "_result"},  32'(bus.result),   32'(res));
    chk({tag, "_dac_fin"}, 32'(bus.dac_code), 32'(res));
    chk({tag, "_ndone"},   32'(dones),        1);
  endtask

  localparam logic [35:0] SEQ_45 = {6'd32, 6'd48, 6'd40, 6'd44, 6'd46, 6'd45};
  localparam logic [35:0] SEQ_63 = {6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63};
  localparam logic [35:0] SEQ_0  = {6'd32, 6'd16, 6'd8,  6'd4,  6'd2,  6'd1};
  localparam logic [35:0] SEQ_39 = {6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd39};

  initial begin
    int dones;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cmp_in = 1'b0;
    tick(2);
    chk_reset("por");
    rst = 1'b0;

    // ideal comparator, level 45
    mode = M_IDEAL;
    conv("ideal", SEQ_45, 6'd45, 1'b0, -1);
    tick(1);
    chk("ideal_idle_busy", 32'(bus.busy), 0);
    chk("ideal_idle_done", 32'(bus.done), 0);
    chk("ideal_hold_res",  32'(bus.result), 45);

    // two-cycle reset in the middle of a conversion with a noisy comparator
    mode = M_RAND;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(10);
    chk("rand_busy_pre", 32'(bus.busy), 1);
    rst = 1'b1;
    tick(1);
    chk_reset("rst1");
    tick(1);
    chk_reset("rst2");
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      tick(1);
      if (bus.done || bus.busy) dones++;
    end
    chk("rst_no_done", 32'(dones), 0);

    // extremes
    mode = M_ONE;
    conv("tie1", SEQ_63, 6'd63, 1'b0, -1);
    tick(1);
    mode = M_ZERO;
    conv("tie0", SEQ_0, 6'd0, 1'b0, -1);
    tick(1);

    // start pulsed during SETTLE of bit 3 is ignored
    mode = M_IDEAL;
    conv("repulse", SEQ_45, 6'd45, 1'b0, 13);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.done || bus.busy) dones++;
    end
    chk("repulse_no_second", 32'(dones), 0);

    // start held high: exactly one IDLE cycle between DONE and SAMPLE
    conv("hold_a", SEQ_45, 6'd45, 1'b1, -1);
    tick(1);
    chk("hold_idle_busy",   32'(bus.busy),   0);
    chk("hold_idle_sample", 32'(bus.sample), 0);
    conv("hold_b", SEQ_45, 6'd45, 1'b0, -1);
    tick(1);

    // abort in DECIDE of bit 2
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(19);
    chk("abort_cmp_en", 32'(bus.cmp_en),   1);
    chk("abort_dac44",  32'(bus.dac_code), 44);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("abort");
    tick(1);
    conv("after_abort", SEQ_45, 6'd45, 1'b0, -1);
    tick(1);

    // synchroniser window
    mode = M_WIN;
    conv("win", SEQ_45, 6'd45, 1'b0, -1);
    tick(1);
    mode = M_LATE;
    conv("late", SEQ_39, 6'd39, 1'b0, -1);
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
